// File: rtl/core_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
package core_pkg;

    // FSM states; the numeric value is exported on state_dbg.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    // ALUControl encodings understood by the datapath ALU.
    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_ORR = 4'b0011,
        ALU_EOR = 4'b0100,
        ALU_MOV = 4'b0101
    } alu_op_t;

    // Condition field codes.
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_t;

    // Instruction op field.
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // Data-processing cmd field (funct[4:1]).
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // ALUSrcB and ResultSrc mux selects.
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Decoded view of a data-processing cmd.
    typedef struct packed {
        logic    ok;     // cmd is implemented
        logic    arith;  // updates C and V when flags are set
        logic    cmp;    // compare: flags only, no register write
        alu_op_t op;
    } dp_ctl_t;

    function automatic dp_ctl_t dp_decode(input logic [3:0] cmd);
        dp_ctl_t d;
        d = '{ok: 1'b1, arith: 1'b0, cmp: 1'b0, op: ALU_ADD};
        case (cmd)
            CMD_ADD: d.arith = 1'b1;
            CMD_SUB: begin d.op = ALU_SUB; d.arith = 1'b1; end
            CMD_CMP: begin d.op = ALU_SUB; d.arith = 1'b1; d.cmp = 1'b1; end
            CMD_AND: d.op = ALU_AND;
            CMD_ORR: d.op = ALU_ORR;
            CMD_EOR: d.op = ALU_EOR;
            CMD_MOV: d.op = ALU_MOV;
            default: d.ok = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Condition evaluator: decides whether the current instruction may commit,
// from its cond field and the stored NZCV flags.
module cond_check
    import core_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    // Map each condition code onto its flag predicate.
    always_comb begin
        // NOTE: assigning a default first guarantees no latch even if a code is missed.
        cond_ex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control unit: steps one instruction through fetch/decode/execute/
// writeback, holds NZCV, and suppresses architectural writes when cond fails.
module multicycle_controller
    import core_pkg::*;
#(
    parameter int ALUCW   = 4,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        Instr,
    input  logic               flag_N,
    input  logic               flag_Z,
    input  logic               flag_C,
    input  logic               flag_V,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegSrc,
    output logic [1:0]         ImmSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUCW-1:0]   ALUControl,
    output logic [1:0]         ResultSrc,
    output logic [STATE_W-1:0] state_dbg
);

    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       unused_rn;
    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign unused_rn = ^Instr[7:4];
    assign rd        = Instr[3:0];
    assign cmd       = funct[4:1];

    state_t     state, state_next;
    logic [3:0] nzcv, nzcv_next;
    logic       cond_ex, dp_write;
    dp_ctl_t    dp;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] reg_src, imm_src, alu_src_b, result_src;
    alu_op_t    alu_op;

    assign dp       = dp_decode(cmd);
    assign dp_write = cond_ex & dp.ok & ~dp.cmp;

    cond_check u_cond_check (
        .cond    (cond),
        .nzcv    (nzcv),
        .cond_ex (cond_ex)
    );

    // State and flag registers; reset returns to FETCH with flags cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            nzcv  <= 4'b0000;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_next;
            nzcv  <= nzcv_next;
        end
    end

    // Next-state, flag-update and control decode from the current state.
    always_comb begin
        state_next = FETCH;
        nzcv_next  = nzcv;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        imm_src    = (op == OP_UNDEF) ? 2'b00 : op;
        reg_src    = {op == OP_MEM, op == OP_BR};
        case (state)
            FETCH: begin
                imm_src    = 2'b00;
                reg_src    = 2'b00;
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_next = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                case (op)
                    OP_MEM:  state_next = MEMADR;
                    OP_DP:   state_next = funct[5] ? EXECI : EXECR;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b  = SRCB_IMM;
                alu_op     = funct[3] ? ALU_ADD : ALU_SUB;
                state_next = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src    = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                adr_src    = 1'b1;
                result_src = RES_DATA;
                reg_write  = cond_ex;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex;
            end
            EXECR, EXECI: begin
                alu_src_b  = (state == EXECI) ? SRCB_IMM : SRCB_REG;
                alu_op     = dp.op;
                state_next = ALUWB;
            end
            ALUWB: begin
                // ALU inputs are held so the flags seen here belong to this op.
                alu_src_b = funct[5] ? SRCB_IMM : SRCB_REG;
                alu_op    = dp.op;
                reg_write = dp_write;
                pc_write  = dp_write & (rd == 4'd15);
                if (cond_ex && dp.ok) begin
                    if (dp.cmp) begin
                        nzcv_next = {flag_N, flag_Z, flag_C, flag_V};
                    end else if (funct[0]) begin
                        nzcv_next[3:2] = {flag_N, flag_Z};
                        if (dp.arith) nzcv_next[1:0] = {flag_C, flag_V};
                    end
                end
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = 2'b10;
                result_src = RES_ALURESULT;
                pc_write   = cond_ex;
                reg_write  = cond_ex & funct[4];
            end
            default: state_next = FETCH;
        endcase
    end

    // Outputs are forced idle while reset is held so nothing commits on release.
    assign PCWrite    = reset & pc_write;
    assign AdrSrc     = reset & adr_src;
    assign MemWrite   = reset & mem_write;
    assign IRWrite    = reset & ir_write;
    assign RegWrite   = reset & reg_write;
    assign ALUSrcA    = reset & alu_src_a;
    assign RegSrc     = reset ? reg_src    : 2'b00;
    assign ImmSrc     = reset ? imm_src    : 2'b00;
    assign ALUSrcB    = reset ? alu_src_b  : 2'b00;
    assign ResultSrc  = reset ? result_src : 2'b00;
    assign ALUControl = reset ? ALUCW'(alu_op) : '0;
    assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level reference
// model, directed scenarios, randomized instruction stream, and an exhaustive
// sweep of the standalone condition checker.
module tb_multicycle_controller;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic        flag_N, flag_Z, flag_C, flag_V;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
    logic [3:0]  ALUControl, state_dbg;

    logic [3:0]  cc_cond, cc_nzcv;
    logic        cc_ex;

    always #5 clk = ~clk;

    multicycle_controller #(.ALUCW(4), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Instr(Instr),
        .flag_N(flag_N), .flag_Z(flag_Z), .flag_C(flag_C), .flag_V(flag_V),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .state_dbg(state_dbg)
    );

    cond_check u_cc (.cond(cc_cond), .nzcv(cc_nzcv), .cond_ex(cc_ex));

    // Expected control word: state plus every output, in one vector.
    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] regsrc, immsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [3:0] aluc;
        logic [1:0] res;
    } ctl_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         instr_no = 0;
    logic [3:0] m_nzcv;
    logic       tab_ok [16];
    logic       tab_cv [16];
    logic [3:0] tab_op [16];
    logic [7:0] rw_tr, pcw_tr, adr_tr, mw_tr, irw_tr;
    logic [3:0] sup [7] = '{4'h4, 4'h2, 4'h0, 4'hC, 4'h1, 4'hD, 4'hA};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Condition truth: predicate picked by cond[3:1], inverted by cond[0].
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] f, input logic [3:0] rd);
        return {c, op, f, 4'h2, rd};
    endfunction

    function automatic int n_steps(input logic [19:0] ins);
        case (ins[15:14])
            2'b00:   return 4;
            2'b01:   return ins[8] ? 5 : 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    // What the controller must drive on cycle `step` of instruction `ins`.
    function automatic ctl_t expect_out(input logic [19:0] ins, input int step, input logic cex);
        ctl_t       e;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] cmd;
        logic       wr;
        e = '0;
        op = ins[15:14]; f = ins[13:8]; cmd = f[4:1];
        if (step == 0) begin
            e.st = FETCH; e.irw = 1; e.pcw = 1; e.srca = 1; e.srcb = 2'b10;
            e.aluc = ALU_ADD; e.res = 2'b10;
            return e;
        end
        e.immsrc = (op == 2'b11) ? 2'b00 : op;
        e.regsrc = {op == 2'b01, op == 2'b10};
        if (step == 1) begin
            e.st = DECODE; e.srca = 1; e.srcb = 2'b10; e.aluc = ALU_ADD; e.res = 2'b10;
            return e;
        end
        case (op)
            2'b00: begin
                e.srcb = f[5] ? 2'b01 : 2'b00;
                e.aluc = tab_op[cmd];
                if (step == 2) e.st = f[5] ? EXECI : EXECR;
                else begin
                    wr = cex & tab_ok[cmd] & (cmd != 4'hA);
                    e.st = ALUWB; e.rw = wr; e.pcw = wr & (ins[3:0] == 4'd15);
                end
            end
            2'b01: begin
                if (step == 2) begin
                    e.st = MEMADR; e.srcb = 2'b01; e.aluc = f[3] ? ALU_ADD : ALU_SUB;
                end else if (step == 3 && f[0]) begin
                    e.st = MEMRD; e.adr = 1;
                end else if (step == 3) begin
                    e.st = MEMWR; e.adr = 1; e.mw = cex;
                end else begin
                    e.st = MEMWB; e.adr = 1; e.res = 2'b01; e.rw = cex;
                end
            end
            default: begin
                e.st = BRANCH; e.srcb = 2'b01; e.aluc = ALU_ADD; e.res = 2'b10;
                e.pcw = cex; e.rw = cex & f[4];
            end
        endcase
        return e;
    endfunction

    // Run one instruction; abort_at >= 0 pulses reset during that step.
    task automatic run_instr(input logic [19:0] ins, input bit fix_fl, input logic [3:0] fl,
                             input int abort_at);
        int         n;
        logic       cex;
        logic [3:0] drv, cmd;
        ctl_t       e, a;
        n = n_steps(ins);
        cmd = ins[12:9];
        rw_tr = '0; pcw_tr = '0; adr_tr = '0; mw_tr = '0; irw_tr = '0;
        instr_no++;
        for (int s = 0; s < n; s++) begin
            Instr = ins;
            drv = fix_fl ? fl : 4'($urandom);
            {flag_N, flag_Z, flag_C, flag_V} = drv;
            cex = model_cond(ins[19:16], m_nzcv);
            @(negedge clk);
            e = expect_out(ins, s, cex);
            a = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
                 ALUSrcA, ALUSrcB, ALUControl, ResultSrc};
            check($sformatf("ctl_i%0d_s%0d", instr_no, s), 32'(a), 32'(e));
            check($sformatf("nzcv_i%0d_s%0d", instr_no, s), 32'(dut.nzcv), 32'(m_nzcv));
            rw_tr[s] = RegWrite; pcw_tr[s] = PCWrite; adr_tr[s] = AdrSrc;
            mw_tr[s] = MemWrite; irw_tr[s] = IRWrite;
            if (s == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check("rst_async_state", 32'(state_dbg), 32'(FETCH));
                check("rst_async_en", 32'({PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc}), 32'h0);
                check("rst_async_nzcv", 32'(dut.nzcv), 32'h0);
                @(posedge clk); #1;
                check("rst_hold_state", 32'(state_dbg), 32'(FETCH));
                reset = 1'b1;
                m_nzcv = 4'b0000;
                return;
            end
            @(posedge clk);
            if (ins[15:14] == 2'b00 && s == 3 && cex && tab_ok[cmd]) begin
                if (cmd == 4'hA) m_nzcv = drv;
                else if (ins[8]) begin
                    m_nzcv[3:2] = drv[3:2];
                    if (tab_cv[cmd]) m_nzcv[1:0] = drv[1:0];
                end
            end
            #1;
        end
    endtask

    initial begin
        logic [3:0]  c;
        logic [1:0]  op;
        logic [5:0]  f;
        logic [3:0]  rd;

        for (int i = 0; i < 16; i++) begin
            tab_ok[i] = 1'b0; tab_cv[i] = 1'b0; tab_op[i] = ALU_ADD;
        end
        tab_ok[4'h4] = 1; tab_cv[4'h4] = 1; tab_op[4'h4] = ALU_ADD;
        tab_ok[4'h2] = 1; tab_cv[4'h2] = 1; tab_op[4'h2] = ALU_SUB;
        tab_ok[4'hA] = 1; tab_cv[4'hA] = 1; tab_op[4'hA] = ALU_SUB;
        tab_ok[4'h0] = 1; tab_op[4'h0] = ALU_AND;
        tab_ok[4'hC] = 1; tab_op[4'hC] = ALU_ORR;
        tab_ok[4'h1] = 1; tab_op[4'h1] = ALU_EOR;
        tab_ok[4'hD] = 1; tab_op[4'hD] = ALU_MOV;

        // Standalone condition checker over every cond/flag combination.
        for (int i = 0; i < 256; i++) begin
            cc_cond = 4'(i >> 4); cc_nzcv = 4'(i);
            #1;
            check($sformatf("cond_%h_nzcv_%h", cc_cond, cc_nzcv), 32'(cc_ex),
                  32'(model_cond(cc_cond, cc_nzcv)));
        end
        check("cond_eq_z1_lit", 32'(model_cond(4'h0, 4'b0100)), 32'h1);

        // Reset state.
        reset = 1'b0; Instr = '0; {flag_N, flag_Z, flag_C, flag_V} = 4'h0;
        m_nzcv = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(state_dbg), 32'(FETCH));
        check("reset_enables", 32'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite}), 32'h0);
        check("reset_selects", 32'({RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc}), 32'h0);
        check("reset_nzcv", 32'(dut.nzcv), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // ADD R1,R2,#5
        run_instr(mk(4'hE, 2'b00, 6'b101000, 4'd1), 0, 4'h0, -1);
        check("add_rw_trace", 32'(rw_tr), 32'b1000);
        check("add_irw_trace", 32'(irw_tr), 32'b0001);
        // SUBS with Z=1, C=1 -> NZCV 0110
        run_instr(mk(4'hE, 2'b00, 6'b000101, 4'd0), 1, 4'b0110, -1);
        check("subs_nzcv", 32'(dut.nzcv), 32'b0110);
        // BEQ taken, BNE not taken
        run_instr(mk(4'h0, 2'b10, 6'b000000, 4'd0), 0, 4'h0, -1);
        check("beq_pcw_trace", 32'(pcw_tr), 32'b101);
        run_instr(mk(4'h1, 2'b10, 6'b000000, 4'd0), 0, 4'h0, -1);
        check("bne_pcw_trace", 32'(pcw_tr), 32'b001);
        // LDR then STR
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'd4), 0, 4'h0, -1);
        check("ldr_rw_trace", 32'(rw_tr), 32'b10000);
        check("ldr_adr_trace", 32'(adr_tr), 32'b11000);
        run_instr(mk(4'hE, 2'b01, 6'b011000, 4'd4), 0, 4'h0, -1);
        check("str_mw_trace", 32'(mw_tr), 32'b1000);
        // ADDS sets C,V; ANDS with N result keeps them
        run_instr(mk(4'hE, 2'b00, 6'b001001, 4'd2), 1, 4'b0011, -1);
        check("adds_nzcv", 32'(dut.nzcv), 32'b0011);
        run_instr(mk(4'hE, 2'b00, 6'b000001, 4'd2), 1, 4'b1000, -1);
        check("ands_nzcv", 32'(dut.nzcv), 32'b1011);
        // Undefined op: two cycles, only the fetch enables
        run_instr(mk(4'hE, 2'b11, 6'b111111, 4'd15), 0, 4'h0, -1);
        check("undef_rw_trace", 32'(rw_tr | mw_tr), 32'b0);
        check("undef_pcw_trace", 32'(pcw_tr), 32'b01);
        // MOV PC,R3
        run_instr(mk(4'hE, 2'b00, 6'b011010, 4'd15), 0, 4'h0, -1);
        check("movpc_pcw_trace", 32'(pcw_tr), 32'b1001);
        check("movpc_rw_trace", 32'(rw_tr), 32'b1000);
        // Unsupported cmd with S: no write, flags held
        run_instr(mk(4'hE, 2'b00, 6'b001111, 4'd1), 1, 4'b0100, -1);
        check("unsup_rw_trace", 32'(rw_tr), 32'b0);
        check("unsup_nzcv", 32'(dut.nzcv), 32'b1011);
        // cond=1111 never executes
        run_instr(mk(4'hF, 2'b00, 6'b101000, 4'd1), 0, 4'h0, -1);
        check("nv_rw_trace", 32'(rw_tr), 32'b0);
        // Reset pulse during MEMRD of an LDR
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'd4), 0, 4'h0, 3);
        run_instr(mk(4'hE, 2'b00, 6'b101000, 4'd1), 0, 4'h0, -1);
        check("post_rst_rw_trace", 32'(rw_tr), 32'b1000);

        // Randomized instruction stream.
        for (int k = 0; k < 400; k++) begin
            c  = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            if (op == 2'b00 && $urandom_range(0, 3) != 0) f[4:1] = sup[$urandom_range(0, 6)];
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            run_instr(mk(c, op, f, rd), 0, 4'h0,
                      ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 1)) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
